// File: rtl/saturating_adder_pkg.sv
// Shared constants and the saturating-add helper for saturating_adder.
// Operands are zero-extended to MAX_WIDTH, so WIDTH must not exceed MAX_WIDTH.
package saturating_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 8;
  localparam int unsigned DEFAULT_CNT_WIDTH = 16;
  localparam int unsigned MAX_WIDTH         = 64;

  typedef logic [MAX_WIDTH-1:0] wide_t;

  typedef struct packed {
    wide_t result;
    logic  sat;
  } sat_result_t;

  // One extra bit keeps the carry, so any carry-out compares above max.
  function automatic sat_result_t sat_add(input wide_t a, input wide_t b, input wide_t max);
    logic [MAX_WIDTH:0] sum;
    sat_result_t        r;
    sum      = {1'b0, a} + {1'b0, b};
    r.sat    = sum > {1'b0, max};
    r.result = r.sat ? max : sum[MAX_WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/saturating_adder_sat_counter.sv
// Saturating up-counter with synchronous active-high reset and count enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/saturating_adder.sv
// Unsigned saturating adder with registered copy and optional saturation-event
// counter, built only when SATURATING_ADDER_COUNT_EN is defined.
module saturating_adder
  import saturating_adder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [WIDTH-1:0]     max_i,
  output logic [WIDTH-1:0]     output__,
  output logic                 sat_o,
  output logic [WIDTH-1:0]     result_q_o,
  output logic                 sat_q_o,
  output logic [CNT_WIDTH-1:0] sat_count_o
);

  sat_result_t r;

  always_comb begin
    r = sat_add(wide_t'(a_i), wide_t'(b_i), wide_t'(max_i));
  end

  assign output__ = WIDTH'(r.result);
  assign sat_o    = r.sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q_o <= '0;
      sat_q_o    <= 1'b0;
    end else begin
      result_q_o <= output__;
      sat_q_o    <= sat_o;
    end
  end

`ifdef SATURATING_ADDER_COUNT_EN
  sat_counter #(
    .W(CNT_WIDTH)
  ) u_sat_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (sat_o),
    .count(sat_count_o)
  );
`else
  assign sat_count_o = '0;
`endif

endmodule

// File: tb/tb_saturating_adder.sv
// Self-checking bench for saturating_adder: default instance plus a CNT_WIDTH=2
// instance sharing the same inputs, scoreboarded registered outputs.
module tb_saturating_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_i, b_i, max_i;
  logic [7:0]  output__, result_q_o, output2, result_q2;
  logic        sat_o, sat_q_o, sat2, sat_q2;
  logic [15:0] sat_count_o;
  logic [1:0]  sat_count2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       sat;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  always #5 clk = ~clk;

  saturating_adder dut (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .max_i(max_i),
    .output__(output__), .sat_o(sat_o), .result_q_o(result_q_o),
    .sat_q_o(sat_q_o), .sat_count_o(sat_count_o)
  );

  saturating_adder #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .max_i(max_i),
    .output__(output2), .sat_o(sat2), .result_q_o(result_q2),
    .sat_q_o(sat_q2), .sat_count_o(sat_count2)
  );

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    logic [8:0] s;
    exp_t       e;
    s     = {1'b0, a} + {1'b0, b};
    e.sat = s > {1'b0, m};
    e.res = e.sat ? m : s[7:0];
    return e;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef SATURATING_ADDER_COUNT_EN
    return m_cnt;
`else
    return '0;
`endif
  endfunction

  function automatic logic [1:0] exp_cnt2();
`ifdef SATURATING_ADDER_COUNT_EN
    return m_cnt2;
`else
    return '0;
`endif
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    a_i   = a;
    b_i   = b;
    max_i = m;
    q.push_back(model(a, b, m));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counter model advance for an edge with rst low.
  task automatic bump(input logic s);
    if (s && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
    if (s && m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_i = 8'd0; b_i = 8'd0; max_i = 8'd0;
    tick();
    tick();
    m_cnt = '0; m_cnt2 = '0;
    total++; if (result_q_o !== 8'd0) begin bad++; $display("FAIL reset_result got=%0d want=0", result_q_o); end
    total++; if (sat_q_o !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b want=0", sat_q_o); end
    total++; if (sat_count_o !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", sat_count_o); end
    total++; if (sat_count2 !== 2'd0) begin bad++; $display("FAIL reset_count2 got=%0d want=0", sat_count2); end
    rst = 1'b0;
  endtask

  // Combinational + registered path over directed corner vectors.
  task automatic test_vectors();
    logic [7:0] tab [0:9][0:2];
    exp_t e;
    tab = '{'{8'd1, 8'd2, 8'd5}, '{8'd1, 8'd2, 8'd2}, '{8'd200, 8'd100, 8'd255},
            '{8'd3, 8'd4, 8'd7}, '{8'd0, 8'd0, 8'd0}, '{8'd1, 8'd0, 8'd0},
            '{8'd255, 8'd255, 8'd255}, '{8'd128, 8'd128, 8'd255},
            '{8'd255, 8'd0, 8'd255}, '{8'd10, 8'd20, 8'd29}};
    for (int i = 0; i < 10; i++) begin
      drive(tab[i][0], tab[i][1], tab[i][2]);
      #1;
      e = model(tab[i][0], tab[i][1], tab[i][2]);
      total++; if (output__ !== e.res) begin bad++; $display("FAIL vec%0d_out got=%0d want=%0d", i, output__, e.res); end
      total++; if (sat_o !== e.sat) begin bad++; $display("FAIL vec%0d_sat got=%0b want=%0b", i, sat_o, e.sat); end
      tick();
      e = q.pop_front();
      bump(e.sat);
      total++; if (result_q_o !== e.res) begin bad++; $display("FAIL vec%0d_rq got=%0d want=%0d", i, result_q_o, e.res); end
      total++; if (sat_q_o !== e.sat) begin bad++; $display("FAIL vec%0d_sq got=%0b want=%0b", i, sat_q_o, e.sat); end
      total++; if (sat_count_o !== exp_cnt()) begin bad++; $display("FAIL vec%0d_cnt got=%0d want=%0d", i, sat_count_o, exp_cnt()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, m;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      m = 8'($urandom_range(0, 255));
      drive(a, b, m);
      #1;
      e = model(a, b, m);
      total++; if ({output__, sat_o} !== {e.res, e.sat}) begin bad++; $display("FAIL b2b%0d_comb got=%0d/%0b want=%0d/%0b", i, output__, sat_o, e.res, e.sat); end
      tick();
      e = q.pop_front();
      bump(e.sat);
      total++; if ({result_q_o, sat_q_o} !== {e.res, e.sat}) begin bad++; $display("FAIL b2b%0d_reg got=%0d/%0b want=%0d/%0b", i, result_q_o, sat_q_o, e.res, e.sat); end
      total++; if (sat_count_o !== exp_cnt()) begin bad++; $display("FAIL b2b%0d_cnt got=%0d want=%0d", i, sat_count_o, exp_cnt()); end
      total++; if (sat_count2 !== exp_cnt2()) begin bad++; $display("FAIL b2b%0d_cnt2 got=%0d want=%0d", i, sat_count2, exp_cnt2()); end
    end
  endtask

  task automatic test_reset_mid_count();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(8'd1, 8'd2, 8'd2);
      tick();
      e = q.pop_front();
      bump(e.sat);
    end
    total++; if (sat_count_o !== exp_cnt()) begin bad++; $display("FAIL midrst_precount got=%0d want=%0d", sat_count_o, exp_cnt()); end
    drive(8'd1, 8'd2, 8'd2);
    rst = 1'b1;
    #1;
    total++; if ({output__, sat_o} !== {8'd2, 1'b1}) begin bad++; $display("FAIL midrst_comb got=%0d/%0b want=2/1", output__, sat_o); end
    tick();
    void'(q.pop_front());
    m_cnt = '0; m_cnt2 = '0;
    total++; if (sat_count_o !== 16'd0) begin bad++; $display("FAIL midrst_cnt got=%0d want=0", sat_count_o); end
    total++; if (result_q_o !== 8'd0) begin bad++; $display("FAIL midrst_rq got=%0d want=0", result_q_o); end
    total++; if (sat_q_o !== 1'b0) begin bad++; $display("FAIL midrst_sq got=%0b want=0", sat_q_o); end
    total++; if ({output__, sat_o} !== {8'd2, 1'b1}) begin bad++; $display("FAIL midrst_comb2 got=%0d/%0b want=2/1", output__, sat_o); end
    rst = 1'b0;
  endtask

  task automatic test_count_saturate();
    exp_t e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt = '0; m_cnt2 = '0;
    for (int i = 0; i < 5; i++) begin
      drive(8'd200, 8'd100, 8'd255);
      tick();
      e = q.pop_front();
      bump(e.sat);
      total++; if (sat_count2 !== exp_cnt2()) begin bad++; $display("FAIL cntsat%0d_cnt2 got=%0d want=%0d", i, sat_count2, exp_cnt2()); end
    end
`ifdef SATURATING_ADDER_COUNT_EN
    total++; if (sat_count2 !== 2'd3) begin bad++; $display("FAIL cntsat_final got=%0d want=3", sat_count2); end
    total++; if (sat_count_o !== 16'd5) begin bad++; $display("FAIL cntsat_wide got=%0d want=5", sat_count_o); end
`else
    total++; if (sat_count2 !== 2'd0) begin bad++; $display("FAIL cntsat_final got=%0d want=0", sat_count2); end
    total++; if (sat_count_o !== 16'd0) begin bad++; $display("FAIL cntsat_wide got=%0d want=0", sat_count_o); end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt  = '0;
    m_cnt2 = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_count();
    test_count_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saturating_adder.md
SATURATING_ADDER -- requirements
Module: saturating_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width.
REQ-002 Parameter CNT_WIDTH, default 16, saturation-event counter width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port a_i  input  WIDTH  unsigned operand A.
REQ-006 Port b_i  input  WIDTH  unsigned operand B.
REQ-007 Port max_i  input  WIDTH  unsigned saturation ceiling.
REQ-008 Port output__  output  WIDTH  combinational saturated sum.
REQ-009 Port sat_o  output  1  combinational flag, high when output__ is clamped.
REQ-010 Port result_q_o  output  WIDTH  output__ registered, one-cycle latency.
REQ-011 Port sat_q_o  output  1  sat_o registered, aligned with result_q_o.
REQ-012 Port sat_count_o  output  CNT_WIDTH  count of cycles with sat_o high.

Function
REQ-013 The block SHALL form sum = a_i + b_i in WIDTH+1 bits, unsigned, so the carry is never lost.
REQ-014 output__ SHALL equal max_i when sum > max_i, else sum[WIDTH-1:0]; zero latency, no clock involvement.
REQ-015 sat_o SHALL be 1 exactly when sum > max_i; sum == max_i gives output__ = max_i with sat_o = 0.
REQ-016 A carry-out (sum >= 2^WIDTH) SHALL always saturate to max_i, including when max_i is all-ones.
REQ-017 max_i = 0 SHALL force output__ = 0, with sat_o = 1 whenever sum is nonzero.
REQ-018 Input changes SHALL propagate to output__ and sat_o within the same cycle, with no intermediate registered state.
REQ-019 result_q_o and sat_q_o SHALL load output__ and sat_o on every rising clk edge when rst is low.
REQ-020 sat_count_o SHALL increment by 1 on each rising edge where sat_o = 1 and rst = 0.
REQ-021 sat_count_o SHALL hold at all-ones once reached and SHALL never wrap.

Reset
REQ-022 When rst is high at a rising edge, result_q_o, sat_q_o and sat_count_o SHALL all become 0.
REQ-023 Reset SHALL have no effect on output__ or sat_o, which stay purely combinational during reset.
REQ-024 Reset asserted mid-count SHALL take priority over an increment in the same cycle.

Configuration
REQ-025 Macro SATURATING_ADDER_COUNT_EN SHALL control the saturation counter.
REQ-026 With SATURATING_ADDER_COUNT_EN defined, sat_count_o SHALL behave per REQ-020/021.
REQ-027 Without SATURATING_ADDER_COUNT_EN, no counter logic SHALL be built and sat_count_o SHALL be constant 0.
REQ-028 The port list SHALL be identical in both builds.

Structure
REQ-029 Package saturating_adder_pkg SHALL hold the default WIDTH and CNT_WIDTH constants and the helper function computing the saturated result and flag.
REQ-030 Sub-module sat_counter (saturating up-counter with synchronous reset and enable) SHALL implement the counter, instantiated only under the macro.

Verification
REQ-031 a=1, b=2, max=5 -> output__=3, sat_o=0 within 1 time unit; after the next edge result_q_o=3.
REQ-032 a=1, b=2, max=2 -> output__=2, sat_o=1; one edge later sat_q_o=1, sat_count_o increments by 1.
REQ-033 a=200, b=100, max=255 (carry) -> output__=255, sat_o=1; a=3, b=4, max=7 -> output__=7, sat_o=0.
REQ-034 max=0 with a=0, b=0 -> output__=0, sat_o=0; with a=1, b=0 -> output__=0, sat_o=1.
REQ-035 Hold a saturating input and pulse rst for one cycle mid-count -> sat_count_o, result_q_o and sat_q_o read 0 after that edge; output__ stays correct throughout.
REQ-036 With CNT_WIDTH=2, saturate for 5 cycles -> sat_count_o stops at 3; in the build without the macro, sat_count_o stays 0.
